store_buffer: RTL and testbench

Write-through store buffer between the two-way data cache and `data_mem`. It accepts byte-enabled stores from the cache side, holds them in a small FIFO, and drains them one per handshake to main memory. Stores to the youngest non-head entry's word are coalesced into that entry. Loads get same-cycle byte-wise forwarding from pending stores so they never read stale memory.

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/store_buffer_fwd.sv | 49 ++++
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the write-through store buffer between the
// two-way data cache and data_mem.
package store_buffer_pkg;

   localparam int SB_ADDR_WIDTH = 32;
   localparam int SB_DATA_WIDTH = 32;
   localparam int BE_WIDTH      = SB_DATA_WIDTH / 8;

   // Cache-side AddrMode code for stores; the integrating logic decodes it into st_be.
   typedef enum logic [2:0] {
      ADDR_MODE_STORE = 3'b111
   } addr_mode_t;

   typedef struct packed {
      logic [SB_ADDR_WIDTH-3:0] word;
      logic [SB_DATA_WIDTH-1:0] data;
      logic [BE_WIDTH-1:0]      be;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Per-byte-lane youngest-match selector. It forwards pending store bytes to a
// load in the same cycle.
module store_buffer_fwd
   import store_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic [ADDR_WIDTH-3:0]          word [DEPTH],
   input  logic [DATA_WIDTH-1:0]          data [DEPTH],
   input  logic [DATA_WIDTH/8-1:0]        be   [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]       head,
   input  logic [$clog2(DEPTH+1)-1:0]     count,
   input  logic [ADDR_WIDTH-1:0]          ld_addr,
   output logic [DATA_WIDTH/8-1:0]        fwd_be,
   output logic [DATA_WIDTH-1:0]          fwd_data
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int BEW = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-3:0] ld_word;
   logic [PW-1:0]         idx;
   logic                  unused_ld_lsb;

   assign ld_word       = ld_addr[ADDR_WIDTH-1:2];
   assign unused_ld_lsb = ^ld_addr[1:0];

   // Walk oldest to youngest so a younger matching byte overwrites an older one.
   always_comb begin
      fwd_be   = '0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (word[idx] == ld_word)) begin
            for (int b = 0; b < BEW; b++) begin
               if (be[idx][b]) begin
                  fwd_be[b]          = 1'b1;
                  fwd_data[8*b +: 8] = data[idx][8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Write-through store buffer: a circular FIFO of byte-enabled stores. It merges
// a store into the youngest entry when that entry is not the head, and drains
// one entry per memory handshake.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         st_valid,
   output logic                         st_ready,
   input  logic [ADDR_WIDTH-1:0]        st_addr,
   input  logic [DATA_WIDTH-1:0]        st_data,
   input  logic [DATA_WIDTH/8-1:0]      st_be,
   input  logic [ADDR_WIDTH-1:0]        ld_addr,
   output logic [DATA_WIDTH/8-1:0]      fwd_be,
   output logic [DATA_WIDTH-1:0]        fwd_data,
   output logic                         fwd_hit,
   output logic                         mem_valid,
   input  logic                         mem_ready,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [DATA_WIDTH-1:0]        mem_data,
   output logic [DATA_WIDTH/8-1:0]      mem_be,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic [31:0]                  merge_count
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int BEW = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-3:0] word_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [BEW-1:0]        be_q   [DEPTH];
   logic [PW-1:0]         head_q, tail_q, last_idx;
   logic [CW-1:0]         count_q;
   logic [31:0]           merge_count_q;
   logic                  merge, enq, deq;
   logic                  unused_st_lsb;

   assign unused_st_lsb = ^st_addr[1:0];

   // Only the youngest entry is a merge target, and only when it is not the
   // head, because the head may already be on the memory bus.
   assign last_idx = tail_q - PW'(1);
   assign merge    = st_valid && (count_q >= CW'(2))
                     && (st_addr[ADDR_WIDTH-1:2] == word_q[last_idx]);
   assign st_ready = (count_q < CW'(DEPTH)) || merge;
   assign enq      = st_valid && st_ready && !merge;
   assign deq      = mem_valid && mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else if (merge) begin
         for (int b = 0; b < BEW; b++) begin
            if (st_be[b]) data_q[last_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
         be_q[last_idx] <= be_q[last_idx] | st_be;
      end else if (enq) begin
         word_q[tail_q] <= st_addr[ADDR_WIDTH-1:2];
         data_q[tail_q] <= st_data;
         be_q[tail_q]   <= st_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         merge_count_q <= '0;
      end else begin
         if (enq) tail_q <= tail_q + PW'(1);
         if (deq) head_q <= head_q + PW'(1);
         case ({enq, deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (merge) merge_count_q <= merge_count_q + 32'd1;
      end
   end

   assign count       = count_q;
   assign empty       = (count_q == '0);
   assign mem_valid   = !empty;
   assign mem_addr    = {word_q[head_q], 2'b00};
   assign mem_data    = data_q[head_q];
   assign mem_be      = be_q[head_q];
   assign merge_count = merge_count_q;
   assign fwd_hit     = |fwd_be;

   store_buffer_fwd #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fwd (
      .word     (word_q),
      .data     (data_q),
      .be       (be_q),
      .head     (head_q),
      .count    (count_q),
      .ld_addr  (ld_addr),
      .fwd_be   (fwd_be),
      .fwd_data (fwd_data)
   );

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer. It covers reset, drain,
// backpressure with wrap, merging, forwarding and reset in the middle of a drain.
module tb_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_be;
   logic [31:0] ld_addr;
   logic [3:0]  fwd_be;
   logic [31:0] fwd_data;
   logic        fwd_hit;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_be;
   logic [2:0]  count;
   logic        empty;
   logic [31:0] merge_count;

   int vec_count  = 0;
   int miscompares = 0;

   logic [31:0] drain_exp [4] = '{32'h4, 32'h8, 32'hC, 32'h10};

   store_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_be       (st_be),
      .ld_addr     (ld_addr),
      .fwd_be      (fwd_be),
      .fwd_data    (fwd_data),
      .fwd_hit     (fwd_hit),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_be      (mem_be),
      .count       (count),
      .empty       (empty),
      .merge_count (merge_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // This task counts one comparison and reports it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The caller keeps the buffer below full, so the store is accepted on the next edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      st_valid = 1'b1;
      st_addr  = addr;
      st_data  = data;
      st_be    = be;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic doReset();
      st_valid  = 1'b0;
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      #3;
      rst_n     = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b1;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      st_be     = '0;
      ld_addr   = '0;
      mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #2;
      checkOutput("rst_st_ready",    32'(st_ready),  32'd1);
      checkOutput("rst_mem_valid",   32'(mem_valid), 32'd0);
      checkOutput("rst_empty",       32'(empty),     32'd1);
      checkOutput("rst_count",       32'(count),     32'd0);
      checkOutput("rst_fwd_hit",     32'(fwd_hit),   32'd0);
      checkOutput("rst_merge_count", merge_count,    32'd0);
      rst_n = 1'b1;
      tick();

      // Reset and drain
      mem_ready = 1'b1;
      applyStimulus(32'h100, 32'hDEADBEEF, 4'b1111);
      checkOutput("drain_mem_valid", 32'(mem_valid), 32'd1);
      checkOutput("drain_mem_addr",  mem_addr,       32'h100);
      checkOutput("drain_mem_data",  mem_data,       32'hDEADBEEF);
      checkOutput("drain_mem_be",    32'(mem_be),    32'hF);
      tick();
      checkOutput("drain_empty",     32'(empty),     32'd1);
      mem_ready = 1'b0;

      // Fill, backpressure and wrap
      doReset();
      applyStimulus(32'h0, 32'hA0, 4'b1111);
      applyStimulus(32'h4, 32'hA4, 4'b1111);
      applyStimulus(32'h8, 32'hA8, 4'b1111);
      applyStimulus(32'hC, 32'hAC, 4'b1111);
      st_valid = 1'b1;
      st_addr  = 32'h10;
      st_data  = 32'hB0;
      st_be    = 4'b1111;
      #1;
      checkOutput("full_count",    32'(count),    32'd4);
      checkOutput("full_st_ready", 32'(st_ready), 32'd0);
      mem_ready = 1'b1;
      #1;
      checkOutput("full_ready_indep_mem", 32'(st_ready), 32'd0);
      tick();
      mem_ready = 1'b0;
      checkOutput("after_deq_count", 32'(count),    32'd3);
      checkOutput("after_deq_ready", 32'(st_ready), 32'd1);
      tick();
      st_valid = 1'b0;
      checkOutput("wrap_count", 32'(count), 32'd4);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("wrap_drain_addr", mem_addr, drain_exp[i]);
         tick();
      end
      checkOutput("wrap_drain_empty", 32'(empty), 32'd1);
      mem_ready = 1'b0;

      // Merge into the youngest non-head entry
      doReset();
      applyStimulus(32'h20, 32'h11111111, 4'b1111);
      applyStimulus(32'h24, 32'h000000AA, 4'b0001);
      applyStimulus(32'h24, 32'h00BB0000, 4'b0100);
      checkOutput("merge_count_cnt", 32'(count),  32'd2);
      checkOutput("merge_count_val", merge_count, 32'd1);
      ld_addr = 32'h24;
      #1;
      checkOutput("merge_fwd_data", fwd_data,     32'h00BB00AA);
      checkOutput("merge_fwd_be",   32'(fwd_be),  32'h5);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      checkOutput("merge_mem_addr", mem_addr,     32'h24);
      checkOutput("merge_mem_data", mem_data,     32'h00BB00AA);
      checkOutput("merge_mem_be",   32'(mem_be),  32'h5);

      // The head is never merged into; the youngest non-head entry is
      doReset();
      applyStimulus(32'h30, 32'h1, 4'b1111);
      applyStimulus(32'h30, 32'h2, 4'b1111);
      checkOutput("nohead_count", 32'(count),  32'd2);
      checkOutput("nohead_merge", merge_count, 32'd0);
      applyStimulus(32'h30, 32'h3, 4'b0001);
      checkOutput("tail_merge_count", 32'(count),  32'd2);
      checkOutput("tail_merge_merge", merge_count, 32'd1);

      // Forwarding
      doReset();
      ld_addr  = 32'h60;
      st_valid = 1'b1;
      st_addr  = 32'h60;
      st_data  = 32'h12345678;
      st_be    = 4'b1111;
      #1;
      checkOutput("same_cycle_no_fwd", 32'(fwd_hit), 32'd0);
      st_valid = 1'b0;
      doReset();
      applyStimulus(32'h40, 32'h44332211, 4'b1111);
      applyStimulus(32'h44, 32'h00000099, 4'b0001);
      applyStimulus(32'h40, 32'h0000EE00, 4'b0010);
      checkOutput("fwd_count", 32'(count), 32'd3);
      ld_addr = 32'h40;
      #1;
      checkOutput("fwd40_be",   32'(fwd_be), 32'hF);
      checkOutput("fwd40_data", fwd_data,    32'h4433EE11);
      ld_addr = 32'h44;
      #1;
      checkOutput("fwd44_be",   32'(fwd_be), 32'h1);
      checkOutput("fwd44_data", fwd_data,    32'h00000099);
      ld_addr = 32'h50;
      #1;
      checkOutput("fwd50_hit",  32'(fwd_hit), 32'd0);
      checkOutput("fwd50_data", fwd_data,     32'd0);
      ld_addr   = 32'h40;
      mem_ready = 1'b1;
      #1;
      checkOutput("fwd_deq_head_data", fwd_data, 32'h4433EE11);
      tick();
      mem_ready = 1'b0;
      checkOutput("fwd_post_deq_be",   32'(fwd_be), 32'h2);
      checkOutput("fwd_post_deq_data", fwd_data,    32'h0000EE00);

      // Reset mid-operation
      doReset();
      applyStimulus(32'h40, 32'h44332211, 4'b1111);
      applyStimulus(32'h44, 32'h00000099, 4'b0001);
      applyStimulus(32'h48, 32'h00000077, 4'b0001);
      ld_addr = 32'h40;
      checkOutput("mid_pre_valid", 32'(mem_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("mid_count",     32'(count),     32'd0);
      checkOutput("mid_fwd_hit",   32'(fwd_hit),   32'd0);
      checkOutput("mid_empty",     32'(empty),     32'd1);
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
